// File: rtl/pll_rst_seq.sv
// Lock-qualified staged reset sequencer running on the raw board clock.
// Optional lock-loss counter is built only when PLL_RST_LOSS_CNT_EN is defined.
module pll_rst_seq #(
    parameter int LOCK_FILT = 16,
    parameter int HOLD_CYC  = 64,
    parameter int N_STAGES  = 2,
    parameter int STAGE_GAP = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                pll_lock_i,
    input  logic                soft_rst_i,
    output logic [N_STAGES-1:0] rst_n_o,
    output logic                ready_o,
    output logic [2:0]          state_o,
    output logic [7:0]          loss_cnt_o
);

    localparam int REL_SPAN = (N_STAGES - 1) * STAGE_GAP + 1;
    localparam int MAX_A    = (LOCK_FILT > HOLD_CYC) ? LOCK_FILT : HOLD_CYC;
    localparam int MAX_B    = (MAX_A > REL_SPAN) ? MAX_A : REL_SPAN;
    localparam int CW       = (MAX_B > 1) ? $clog2(MAX_B) : 1;

    localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] REL_LAST  = CW'((N_STAGES - 1) * STAGE_GAP);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILTER  = 3'd1,
        HOLD    = 3'd2,
        RELEASE = 3'd3,
        RUN     = 3'd4
    } state_t;

    logic [1:0]          sync;
    logic                lock_s;
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_STAGES-1:0] rst_q, rst_d;
    logic                ready_q, ready_d;

    // pll_lock_i is asynchronous to sys_clk; every decision uses the second flop.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], pll_lock_i};
        end
    end

    assign lock_s = sync[1];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        unique case (state_q)
            IDLE: begin
                state_d = FILTER;
                cnt_d   = '0;
                rst_d   = '0;
                ready_d = 1'b0;
            end
            FILTER: begin
                if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == FILT_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = FILTER;
                    cnt_d   = '0;
                    rst_d   = '0;
                    ready_d = 1'b0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    state_d = FILTER;
                    cnt_d   = '0;
                    rst_d   = '0;
                    ready_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    for (int k = 0; k < N_STAGES; k++) begin
                        if (cnt_q == CW'(k * STAGE_GAP)) begin
                            rst_d[k] = 1'b1;
                        end
                    end
                    // Last stage and ready rise on the same edge.
                    if (cnt_q == REL_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        ready_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = FILTER;
                    cnt_d   = '0;
                    rst_d   = '0;
                    ready_d = 1'b0;
                end else if (soft_rst_i) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    rst_d   = '0;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                rst_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    assign rst_n_o = rst_q;
    assign ready_o = ready_q;
    assign state_o = state_q;

`ifdef PLL_RST_LOSS_CNT_EN
    logic       loss_evt;
    logic [7:0] loss_q;

    // A loss is only counted once the lock had qualified (HOLD and later).
    assign loss_evt = !lock_s && ((state_q == HOLD) || (state_q == RELEASE) || (state_q == RUN));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            loss_q <= 8'd0;
        end else if (loss_evt && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign loss_cnt_o = loss_q;
`else
    assign loss_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Scoreboard bench for pll_rst_seq: stimulus queues expected snapshots tagged
// with an edge number, a negedge monitor pops and compares them.
module tb_pll_rst_seq;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       pll_lock_i;
    logic       soft_rst_i;
    logic [1:0] rst_n_o;
    logic       ready_o;
    logic [2:0] state_o;
    logic [7:0] loss_cnt_o;

    typedef struct {
        int          target;
        logic [95:0] tag;
        logic [1:0]  rst;
        logic        rdy;
        logic [2:0]  st;
        logic [7:0]  loss;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_loss = 0;

    pll_rst_seq #(
        .LOCK_FILT(4),
        .HOLD_CYC (8),
        .N_STAGES (2),
        .STAGE_GAP(4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .pll_lock_i(pll_lock_i),
        .soft_rst_i(soft_rst_i),
        .rst_n_o   (rst_n_o),
        .ready_o   (ready_o),
        .state_o   (state_o),
        .loss_cnt_o(loss_cnt_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [7:0] loss_model();
`ifdef PLL_RST_LOSS_CNT_EN
        return (exp_loss > 255) ? 8'd255 : exp_loss[7:0];
`else
        return 8'd0;
`endif
    endfunction

    task automatic expect_at(input int ofs, input logic [95:0] tag, input logic [1:0] r,
                             input logic rdy, input logic [2:0] st);
        exp_t e;
        e.target = edge_cnt + ofs;
        e.tag    = tag;
        e.rst    = r;
        e.rdy    = rdy;
        e.st     = st;
        e.loss   = loss_model();
        sb.push_back(e);
    endtask

    task automatic waitn(input int n);
        repeat (n) @(negedge sys_clk);
        #2;
    endtask

    // Lock seen high from 'base' edges on: HOLD after 6, rst[0] after 15, all after 19.
    task automatic push_release(input int base);
        expect_at(base + 5,  "filt_last",  2'b00, 1'b0, 3'd1);
        expect_at(base + 6,  "hold_entry", 2'b00, 1'b0, 3'd2);
        expect_at(base + 14, "rel_entry",  2'b00, 1'b0, 3'd3);
        expect_at(base + 15, "rel_stage0", 2'b01, 1'b0, 3'd3);
        expect_at(base + 18, "rel_gap",    2'b01, 1'b0, 3'd3);
        expect_at(base + 19, "run_entry",  2'b11, 1'b1, 3'd4);
    endtask

    always @(negedge sys_clk) begin
        while (sb.size() > 0 && sb[0].target <= edge_cnt) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if (e.target != edge_cnt ||
                {rst_n_o, ready_o, state_o, loss_cnt_o} !== {e.rst, e.rdy, e.st, e.loss}) begin
                miscompares++;
                $display("[TB] FAIL %0s @edge %0d: got rst=%b rdy=%b st=%0d loss=%0d, want rst=%b rdy=%b st=%0d loss=%0d",
                         e.tag, edge_cnt, rst_n_o, ready_o, state_o, loss_cnt_o,
                         e.rst, e.rdy, e.st, e.loss);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sys_rst_n  = 1'b0;
        pll_lock_i = 1'b0;
        soft_rst_i = 1'b0;

        waitn(3);
        expect_at(1, "in_reset", 2'b00, 1'b0, 3'd0);
        waitn(2);
        sys_rst_n = 1'b1;
        expect_at(1, "idle_exit", 2'b00, 1'b0, 3'd1);
        expect_at(3, "filt_wait", 2'b00, 1'b0, 3'd1);
        waitn(4);

        $display("[TB] clean lock");
        pll_lock_i = 1'b1;
        push_release(0);
        waitn(22);

        $display("[TB] loss in RUN, relock with ignored soft pulse in HOLD");
        pll_lock_i = 1'b0;
        expect_at(2, "loss_lat2", 2'b11, 1'b1, 3'd4);
        exp_loss++;
        expect_at(3, "loss_lat3", 2'b00, 1'b0, 3'd1);
        waitn(5);
        pll_lock_i = 1'b1;
        push_release(0);
        waitn(8);
        soft_rst_i = 1'b1;
        waitn(1);
        soft_rst_i = 1'b0;
        waitn(13);

        $display("[TB] lock glitch in FILTER");
        pll_lock_i = 1'b0;
        expect_at(2, "pre_glitch", 2'b11, 1'b1, 3'd4);
        exp_loss++;
        expect_at(3, "pre_glitch_l", 2'b00, 1'b0, 3'd1);
        waitn(5);
        pll_lock_i = 1'b1;
        expect_at(6, "glitch_filt", 2'b00, 1'b0, 3'd1);
        push_release(4);
        waitn(3);
        pll_lock_i = 1'b0;
        waitn(1);
        pll_lock_i = 1'b1;
        waitn(22);

        $display("[TB] soft reset in RUN");
        soft_rst_i = 1'b1;
        expect_at(1,  "soft_hold", 2'b00, 1'b0, 3'd2);
        expect_at(9,  "soft_rel",  2'b00, 1'b0, 3'd3);
        expect_at(10, "soft_st0",  2'b01, 1'b0, 3'd3);
        expect_at(14, "soft_run",  2'b11, 1'b1, 3'd4);
        waitn(1);
        soft_rst_i = 1'b0;
        waitn(15);

        $display("[TB] simultaneous soft reset and lock loss");
        pll_lock_i = 1'b0;
        expect_at(2, "simul_pre", 2'b11, 1'b1, 3'd4);
        waitn(2);
        soft_rst_i = 1'b1;
        exp_loss++;
        expect_at(1, "simul_loss", 2'b00, 1'b0, 3'd1);
        waitn(1);
        soft_rst_i = 1'b0;
        waitn(2);

        $display("[TB] async reset during RELEASE");
        pll_lock_i = 1'b1;
        expect_at(6,  "rr_hold",  2'b00, 1'b0, 3'd2);
        expect_at(15, "rr_stage", 2'b01, 1'b0, 3'd3);
        waitn(16);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        exp_loss  = 0;
        expect_at(0, "async_rst", 2'b00, 1'b0, 3'd0);
        waitn(2);
        expect_at(1, "rst_held", 2'b00, 1'b0, 3'd0);
        waitn(1);
        sys_rst_n = 1'b1;
        expect_at(1, "restart", 2'b00, 1'b0, 3'd1);
        push_release(0);
        waitn(22);

        $display("[TB] loss counter saturation");
        pll_lock_i = 1'b0;
        expect_at(2, "sat_pre", 2'b11, 1'b1, 3'd4);
        exp_loss++;
        expect_at(3, "sat_first", 2'b00, 1'b0, 3'd1);
        waitn(5);
        for (int i = 0; i < 300; i++) begin
            pll_lock_i = 1'b1;
            waitn(8);
            pll_lock_i = 1'b0;
            exp_loss++;
            waitn(4);
            if (i == 9 || i == 252 || i == 253 || i == 299) begin
                expect_at(1, "sat_loss", 2'b00, 1'b0, 3'd1);
            end
        end
        waitn(3);

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL sb_drain: got %0d pending entries, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
